// File: rtl/cog_divider.sv
// Centre-of-gravity divider: queues point/marker jobs in a small FIFO and turns each
// point into start_point + sum(I^2*k)/sum(I^2) as an unsigned fixed-point coordinate.
module cog_divider #(
  parameter int FIFO_DEPTH = 4,
  parameter int FRAC_BITS  = 4
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_aresetn,
  input  logic [29:0]            i_sum_of_I_mult_coord,
  input  logic [22:0]            i_sum_of_I,
  input  logic [10:0]            i_start_point,
  input  logic                   i_point_is_valid,
  input  logic                   i_end_of_line,
  input  logic                   i_end_of_frame,
  input  logic                   i_new_frame,
  output logic [10+FRAC_BITS:0]  o_coord,
  output logic [4:0]             o_flags,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_overflow,
  output logic                   o_busy
);
  localparam int DW = 30 + FRAC_BITS;  // dividend / quotient width
  localparam int CW = 11 + FRAC_BITS;  // output coordinate width
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(DW);

  typedef enum logic [2:0] {IDLE, LOAD_DIV, DIV, ADD, OUT} state_t;

  typedef struct packed {
    logic [29:0] mult;
    logic [22:0] dvsr;
    logic [10:0] sp;
    logic        nf;
    logic        eof;
    logic        eol;
    logic        hp;
  } entry_t;

  entry_t        fifo_mem [FIFO_DEPTH];
  entry_t        wr_entry;
  entry_t        head;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          push_req, fifo_full, push, pop;

  state_t        state_reg, state_next;
  logic [22:0]   rem_reg;
  logic [DW-1:0] dq_reg;
  logic [22:0]   divisor_reg;
  logic [10:0]   sp_reg;
  logic [NW-1:0] cnt_reg;
  logic [CW-1:0] coord_reg;
  logic [4:0]    flags_reg;
  logic          valid_reg;
  logic          overflow_reg;

  logic [23:0]   rem_shift, rem_sub;
  logic [DW-1:0] quot;
  logic [DW:0]   sum;

  assign wr_entry  = {i_sum_of_I_mult_coord, i_sum_of_I, i_start_point,
                      i_new_frame, i_end_of_frame, i_end_of_line, i_point_is_valid};
  assign push_req  = i_point_is_valid | i_end_of_line | i_end_of_frame | i_new_frame;
  // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
  assign fifo_full = (count_reg == (AW+1)'(FIFO_DEPTH));
  assign push      = push_req & ~fifo_full;
  assign pop       = (state_reg == IDLE) && (count_reg != '0);
  assign head      = fifo_mem[rd_ptr_reg];

  always_ff @(posedge i_sys_clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= wr_entry;
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
      if (push_req && fifo_full) overflow_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (pop) state_next = head.hp ? DIV : OUT;
      LOAD_DIV: state_next = DIV;
      DIV:      if (cnt_reg == NW'(DW-1)) state_next = ADD;
      ADD:      state_next = OUT;
      OUT:      if (i_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // One restoring step per cycle; a negative trial difference shows up in bit 23
  // because the shifted remainder is always below twice the divisor.
  assign rem_shift = {rem_reg, dq_reg[DW-1]};
  assign rem_sub   = rem_shift - {1'b0, divisor_reg};
  assign quot      = flags_reg[4] ? '0 : dq_reg;
  assign sum       = {{(DW+1-CW){1'b0}}, sp_reg, {FRAC_BITS{1'b0}}} + {1'b0, quot};

  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      state_reg   <= IDLE;
      rem_reg     <= '0;
      dq_reg      <= '0;
      divisor_reg <= '0;
      sp_reg      <= '0;
      cnt_reg     <= '0;
      coord_reg   <= '0;
      flags_reg   <= '0;
      valid_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      valid_reg <= (state_next == OUT);
      case (state_reg)
        IDLE: if (pop) begin
          flags_reg <= {head.hp && (head.dvsr == '0), head.nf, head.eof, head.eol, head.hp};
          if (head.hp) begin
            rem_reg     <= '0;
            dq_reg      <= {head.mult, {FRAC_BITS{1'b0}}};
            divisor_reg <= head.dvsr;
            sp_reg      <= head.sp;
            cnt_reg     <= '0;
          end else begin
            coord_reg   <= '0;
          end
        end
        DIV: begin
          cnt_reg <= cnt_reg + NW'(1);
          if (!rem_sub[23]) begin
            rem_reg <= rem_sub[22:0];
            dq_reg  <= {dq_reg[DW-2:0], 1'b1};
          end else begin
            rem_reg <= rem_shift[22:0];
            dq_reg  <= {dq_reg[DW-2:0], 1'b0};
          end
        end
        ADD: coord_reg <= (|sum[DW:CW]) ? '1 : sum[CW-1:0];
        default: ;
      endcase
    end
  end

  assign o_coord    = coord_reg;
  assign o_flags    = flags_reg;
  assign o_valid    = valid_reg;
  assign o_overflow = overflow_reg;
  assign o_busy     = (state_reg != IDLE) || (count_reg != '0);
endmodule

// File: tb/tb_cog_divider.sv
// Directed and randomized checks of cog_divider against an arithmetic reference model.
module tb_cog_divider;
  localparam int FB = 4;
  localparam int CW = 11 + FB;

  logic          i_sys_clk = 1'b0;
  logic          i_sys_aresetn;
  logic [29:0]   i_sum_of_I_mult_coord;
  logic [22:0]   i_sum_of_I;
  logic [10:0]   i_start_point;
  logic          i_point_is_valid, i_end_of_line, i_end_of_frame, i_new_frame;
  logic [CW-1:0] o_coord;
  logic [4:0]    o_flags;
  logic          o_valid, i_ready, o_overflow, o_busy;

  int pass_cnt = 0;
  int total    = 0;

  cog_divider #(.FIFO_DEPTH(4), .FRAC_BITS(FB)) dut (
    .i_sys_clk(i_sys_clk), .i_sys_aresetn(i_sys_aresetn),
    .i_sum_of_I_mult_coord(i_sum_of_I_mult_coord), .i_sum_of_I(i_sum_of_I),
    .i_start_point(i_start_point), .i_point_is_valid(i_point_is_valid),
    .i_end_of_line(i_end_of_line), .i_end_of_frame(i_end_of_frame),
    .i_new_frame(i_new_frame), .o_coord(o_coord), .o_flags(o_flags),
    .o_valid(o_valid), .i_ready(i_ready), .o_overflow(o_overflow), .o_busy(o_busy)
  );

  always #5 i_sys_clk = ~i_sys_clk;

  task automatic step();
    @(posedge i_sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic longint model_coord(longint mult, longint dv, longint sp, bit pv);
    longint s;
    if (!pv) return 0;
    s = sp * (64'd1 << FB);
    if (dv != 0) s = s + (mult * (64'd1 << FB)) / dv;
    if (s > (64'd1 << CW) - 1) s = (64'd1 << CW) - 1;
    return s;
  endfunction

  function automatic logic [4:0] model_flags(longint dv, bit pv, bit eol, bit eof, bit nf);
    return {pv && (dv == 0), nf, eof, eol, pv};
  endfunction

  task automatic set_in(longint mult, longint dv, longint sp, bit pv, bit eol, bit eof, bit nf);
    i_sum_of_I_mult_coord = mult[29:0];
    i_sum_of_I            = dv[22:0];
    i_start_point         = sp[10:0];
    i_point_is_valid      = pv;
    i_end_of_line         = eol;
    i_end_of_frame        = eof;
    i_new_frame           = nf;
  endtask

  task automatic clear_strobes();
    i_point_is_valid = 0;
    i_end_of_line    = 0;
    i_end_of_frame   = 0;
    i_new_frame      = 0;
  endtask

  task automatic drive(longint mult, longint dv, longint sp, bit pv, bit eol, bit eof, bit nf);
    set_in(mult, dv, sp, pv, eol, eof, nf);
    step();
    clear_strobes();
  endtask

  // One isolated job: strobe in cycle 0, measure latency, hold i_ready low for
  // 'stall' cycles while checking the output is frozen, then transfer.
  task automatic run_job(input string tag, input longint mult, input longint dv, input longint sp,
                         input bit pv, input bit eol, input bit eof, input bit nf, input int stall);
    logic [CW-1:0] c0;
    logic [4:0]    f0;
    int            lat;
    bit            stable;
    i_ready = 0;
    drive(mult, dv, sp, pv, eol, eof, nf);
    lat = 1;
    while (!o_valid && lat < 200) begin
      step();
      lat++;
    end
    check({tag, " latency"}, lat, pv ? 37 : 2);
    check({tag, " coord"}, o_coord, model_coord(mult, dv, sp, pv));
    check({tag, " flags"}, o_flags, model_flags(dv, pv, eol, eof, nf));
    c0 = o_coord;
    f0 = o_flags;
    stable = 1;
    for (int i = 0; i < stall; i++) begin
      step();
      if (o_valid !== 1'b1 || o_coord !== c0 || o_flags !== f0) stable = 0;
    end
    if (stall > 0) check({tag, " hold while not ready"}, stable, 1);
    i_ready = 1;
    step();
    check({tag, " valid drops after transfer"}, o_valid, 0);
    i_ready = 0;
  endtask

  initial begin
    int     extra, lat;
    longint mult, dv, sp;
    bit     pv, eol, eof, nf;

    i_sys_aresetn = 0;
    i_ready = 0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
    check("reset state", {o_valid, o_coord, o_flags, o_overflow, o_busy}, 0);
    i_sys_aresetn = 1;
    step();

    run_job("basic 300/100 sp50", 300, 100, 50, 1, 0, 0, 0, 0);
    check("basic coord literal", dut.o_coord, 848);
    run_job("fraction 250/100 sp10", 250, 100, 10, 1, 0, 0, 0, 0);
    run_job("truncate 1/3 sp0", 1, 3, 0, 1, 0, 0, 0, 0);
    run_job("point+eol", 0, 7, 3, 1, 1, 0, 0, 0);
    run_job("eof marker", 0, 0, 0, 0, 0, 1, 0, 0);
    run_job("div by zero stall10", 12345, 0, 100, 1, 0, 0, 0, 10);
    run_job("saturate", 30'h3FFFFFFF, 1, 2047, 1, 0, 0, 0, 0);
    run_job("nf with point", 1000, 7, 900, 1, 0, 0, 1, 2);
    run_job("all markers", 5, 5, 5, 0, 1, 1, 1, 1);

    // Six back-to-back points: the sixth meets a full FIFO and is dropped.
    i_ready = 1;
    for (int k = 0; k < 6; k++) begin
      set_in(k + 1, 2, 10 * k, 1, 0, 0, 0);
      if (k == 5) check("overflow clear before drop", o_overflow, 0);
      step();
    end
    clear_strobes();
    check("overflow set at cycle 6", o_overflow, 1);
    for (int k = 0; k < 5; k++) begin
      lat = 0;
      while (!o_valid && lat < 200) begin
        step();
        lat++;
      end
      check($sformatf("burst out %0d valid", k), o_valid, 1);
      check($sformatf("burst out %0d coord", k), o_coord, model_coord(k + 1, 2, 10 * k, 1));
      step();
    end
    extra = 0;
    repeat (60) begin
      step();
      if (o_valid) extra++;
    end
    check("burst no sixth output", extra, 0);
    check("burst idle", o_busy, 0);
    check("overflow sticky", o_overflow, 1);
    i_ready = 0;

    for (int n = 0; n < 20; n++) begin
      mult = longint'($urandom) & 64'h3FFF_FFFF;
      dv   = ($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 20))
                                         : (longint'($urandom) & 64'h7F_FFFF);
      sp   = longint'($urandom_range(0, 2047));
      pv   = ($urandom_range(0, 3) != 0);
      eol  = $urandom_range(0, 1) != 0;
      eof  = $urandom_range(0, 1) != 0;
      nf   = $urandom_range(0, 1) != 0;
      if (!pv && !eol && !eof && !nf) eol = 1;
      run_job($sformatf("rand %0d", n), mult, dv, sp, pv, eol, eof, nf, $urandom_range(0, 3));
    end

    // Abort a division with two jobs queued behind it.
    i_ready = 1;
    drive(4000, 3, 7, 1, 0, 0, 0);
    drive(10, 2, 1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    repeat (14) step();
    check("busy mid-division", o_busy, 1);
    #1;
    i_sys_aresetn = 0;
    #1;
    check("async reset clears outputs", {o_valid, o_coord, o_flags, o_overflow, o_busy}, 0);
    step();
    step();
    i_sys_aresetn = 1;
    extra = 0;
    repeat (60) begin
      step();
      if (o_valid || o_busy) extra++;
    end
    check("no residue after reset", extra, 0);
    run_job("after reset", 300, 100, 50, 1, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/cog_divider.md
COG_DIVIDER -- requirements
Module: cog_divider

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, input job FIFO depth in entries; power of 2, at least 2.
REQ-002 SHALL have parameter FRAC_BITS, default 4, number of fractional bits in the output coordinate.
REQ-003 SHALL have port i_sys_clk, input, 1 bit: the single clock, rising-edge.
REQ-004 SHALL have port i_sys_aresetn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port i_sum_of_I_mult_coord, input, 30 bits: dividend, sum of I^2*k.
REQ-006 SHALL have port i_sum_of_I, input, 23 bits: divisor, sum of I^2.
REQ-007 SHALL have port i_start_point, input, 11 bits: figure start coordinate.
REQ-008 SHALL have port i_point_is_valid, input, 1 bit: 1-cycle strobe; the operands above are valid in this cycle.
REQ-009 SHALL have ports i_end_of_line, i_end_of_frame, i_new_frame, input, 1 bit each: 1-cycle markers aligned with the point stream.
REQ-010 SHALL have port o_coord, output, 11+FRAC_BITS bits: unsigned fixed-point coordinate.
REQ-011 SHALL have port o_flags, output, 5 bits: {div_zero, new_frame, end_of_frame, end_of_line, has_point}.
REQ-012 SHALL have port o_valid, output, 1 bit: o_coord/o_flags valid.
REQ-013 SHALL have port i_ready, input, 1 bit: downstream accepts the output.
REQ-014 SHALL have port o_overflow, output, 1 bit: sticky, set when an entry has been dropped.
REQ-015 SHALL have port o_busy, output, 1 bit: high when the FSM is not IDLE or the FIFO is non-empty.

Function
REQ-016 SHALL write one FIFO entry {operands, has_point=i_point_is_valid, eol, eof, nf} in any cycle where at least one of the four strobes is high; simultaneous strobes SHALL form one entry.
REQ-017 SHALL judge FIFO full before any same-cycle pop; a write to a full FIFO SHALL be dropped and SHALL set o_overflow, which stays set until reset.
REQ-018 SHALL implement the FSM states IDLE, LOAD_DIV, DIV, ADD, OUT.
REQ-019 In IDLE with the FIFO non-empty, the FSM SHALL pop one entry: with has_point=1 it SHALL register the operands and go to DIV; otherwise it SHALL register the flags, set o_coord=0, and go to OUT.
REQ-020 DIV SHALL run restoring division of {dividend, FRAC_BITS zeros} by the divisor, one quotient bit per cycle, for 30+FRAC_BITS cycles, then go to ADD.
REQ-021 ADD SHALL compute (i_start_point << FRAC_BITS) + quotient, truncating (no rounding), and saturate to all-ones if the result exceeds 11+FRAC_BITS bits; it then goes to OUT.
REQ-022 If the divisor is 0, the divider SHALL produce quotient 0, o_coord = start_point << FRAC_BITS, and div_zero=1, with the same latency.
REQ-023 In OUT, o_valid SHALL be 1; o_coord and o_flags SHALL hold stable until i_ready=1; on o_valid & i_ready the FSM SHALL return to IDLE. Back-to-back pop in the same cycle is not required.
REQ-024 Latency from strobe cycle 0 to o_valid, with the FIFO empty and the FSM in IDLE: point entry 37 cycles (FRAC_BITS=4); marker-only entry 2 cycles.
REQ-025 Output order SHALL equal input order; within one entry, consumers interpret nf as before the point and eol/eof as after it.
REQ-026 o_valid SHALL be registered; o_valid SHALL NOT depend combinationally on i_ready.

Reset
REQ-027 Reset assertion SHALL asynchronously empty the FIFO, set the FSM to IDLE, and clear o_valid, o_coord, o_flags, o_overflow and o_busy to 0, including mid-division.
REQ-028 After reset release, the first strobe SHALL be processed normally with no residue from aborted jobs.

Verification
REQ-029 Input sum_mult=300, sum_I=100, sp=50, i_ready=1 -> o_coord=848 (0x350), flags=00001, o_valid high in cycle 37.
REQ-030 Input sum_mult=250, sum_I=100, sp=10 -> o_coord=200 (2.5 fractional); input sum_mult=1, sum_I=3, sp=0 -> o_coord=5 (truncated).
REQ-031 Point and i_end_of_line in the same cycle, sum_mult=0, sum_I=7, sp=3 -> one output, o_coord=48, flags=00011; i_end_of_frame alone -> o_coord=0, flags=00100, at cycle 2.
REQ-032 Six point strobes on consecutive cycles 0..5, i_ready=1 -> five outputs in order, sixth dropped, o_overflow=1 from cycle 6.
REQ-033 sum_I=0, sp=100 -> o_coord=1600, flags=10001; i_ready held 0 for 10 cycles in OUT -> outputs stable, then one transfer.
REQ-034 Reset asserted at cycle 15 of DIV with 2 entries queued -> all outputs 0 immediately; no outputs after release until new strobes arrive.
